// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

   // Receiver FSM states.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      RECOVER
   } rx_state_e;

   // Clock cycles per serial bit (integer division, truncating).
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO for received bytes, with overrun detection.
// Pointers carry one extra wrap bit so that full and empty are distinguishable
// without a separate occupancy counter.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             overrun
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             empty;
   logic             full;
   logic             do_pop;
   logic             do_push;

   assign empty    = (wptr == rptr);
   assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop   = rd_en && !empty;
   // A simultaneous pop frees the head slot, so a push into a full FIFO is
   // still accepted in that cycle.
   assign do_push  = wr_en && (!full || do_pop);
   assign rd_valid = !empty;
   // Head byte reads as zero while empty so the output matches its reset value.
   assign rd_data  = empty ? '0 : mem[rptr[AW-1:0]];

   // Pointer advance and one-cycle overrun pulse for a dropped byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr    <= '0;
         rptr    <= '0;
         overrun <= 1'b0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         overrun <= wr_en && full && !do_pop;
      end
   end

   // Storage write; contents are only observable through the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with mid-bit sampling and a small output FIFO.
// Output handshake: rx_valid is high whenever the FIFO holds a byte and
// rx_data shows the head byte; the byte is consumed at the clock edge where
// rx_valid && rx_ready are both high. rx_ready while rx_valid is low is ignored,
// and rx_valid/rx_data never depend combinationally on rx_ready.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int            CPB      = clks_per_bit(CLK_FREQ, BAUD);
   localparam int            CW       = (CPB > 1) ? $clog2(CPB) : 1;
   localparam logic [CW-1:0] FULL_LIM = CW'(CPB - 1);
   localparam logic [CW-1:0] HALF_LIM = CW'(CPB / 2 - 1);

   logic          rx_meta;
   logic          rx_s;
   rx_state_e     state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          at_limit;
   logic          push;

   // Bring the asynchronous line into the clock domain; idles high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // The start bit is checked at half a bit time so later samples land mid-bit.
   assign at_limit = (state == START) ? (cnt == HALF_LIM) : (cnt == FULL_LIM);
   assign push     = (state == STOP) && at_limit && rx_s;

   // Frame sequencing; busy and frame_err are registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               if (!rx_s) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (at_limit) begin
                  cnt <= '0;
                  if (rx_s) begin
                     // Line went back high before mid start bit: a glitch.
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= DATA;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (at_limit) begin
                  cnt     <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (at_limit) begin
                  cnt <= '0;
                  if (rx_s) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state     <= RECOVER;
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RECOVER: begin
               // A break or stuck-low line must release before a new frame.
               cnt <= '0;
               if (rx_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (push),
      .wr_data  (shreg),
      .rd_en    (rx_ready),
      .rd_data  (rx_data),
      .rd_valid (rx_valid),
      .overrun  (overrun)
   );

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at a reduced bit time (32 clocks per bit).
module tb_uart_rx_core;

   localparam int CLK_FREQ   = 3_200_000;
   localparam int BAUD       = 100_000;
   localparam int CPB        = CLK_FREQ / BAUD;
   localparam int HALF       = CPB / 2;
   localparam int FIFO_DEPTH = 4;
   // Edges from driving the start bit low until rx_valid is seen high.
   localparam int NOM_LAT    = 2 + HALF + 9 * CPB + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   uart_rx_core #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #(5_000_000);
      $display("FAIL watchdog: time limit reached, got no summary, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- monitor ----------------
   int         ferr_total = 0;
   int         ovr_total = 0;
   int         valid_cycles = 0;
   int         got_cnt = 0;
   int         valid_rise_cyc = -1;
   int         busy_rise_cyc = -1;
   int         busy_fall_cyc = -1;
   logic [7:0] got_mem [0:255];
   logic       valid_q = 1'b0;
   logic       busy_q = 1'b0;

   always @(negedge clk) begin
      if (frame_err) ferr_total <= ferr_total + 1;
      if (overrun)   ovr_total  <= ovr_total + 1;
      if (rx_valid)  valid_cycles <= valid_cycles + 1;
      if (rx_valid && rx_ready) begin
         got_mem[got_cnt[7:0]] <= rx_data;
         got_cnt <= got_cnt + 1;
      end
      if (rx_valid && !valid_q) valid_rise_cyc <= cyc;
      if (busy && !busy_q)      busy_rise_cyc  <= cyc;
      if (!busy && busy_q)      busy_fall_cyc  <= cyc;
      valid_q <= rx_valid;
      busy_q  <= busy;
   end

   // ---------------- scoreboard ----------------
   int         vec_count = 0;
   int         miscompares = 0;
   logic [7:0] exp_q [$];
   int         rd_idx = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_count++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      vec_count++;
      if (act < lo || act > hi) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Compare every accepted byte so far against the expected queue, in order.
   task automatic check_bytes(input string name);
      logic [7:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd_idx < got_cnt) begin
            check($sformatf("%s_byte%0d", name, rd_idx), got_mem[rd_idx[7:0]], e);
         end else begin
            check($sformatf("%s_missing_byte", name), 32'hFFFF_FFFF, e);
         end
         rd_idx++;
      end
      check($sformatf("%s_no_extra_bytes", name), got_cnt, rd_idx);
   endtask

   // ---------------- drivers ----------------
   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop_b);
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * CPB) @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] data;
      logic       stop_b;
      logic       exp_push;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs [6];

   int         cnt0;
   int         ferr0;
   int         ovr0;
   int         vc0;
   int         br0;
   int         start_cyc;
   logic [7:0] pd;

   initial begin
      vecs[0] = '{8'h54, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{8'hA5, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{8'h81, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b0};

      // Reset state.
      rst_n = 1'b0;
      rx = 1'b1;
      rx_ready = 1'b0;
      wait_cycles(3);
      check("reset_outputs", {rx_data, rx_valid, frame_err, overrun, busy}, 32'h0);
      rst_n = 1'b1;
      wait_cycles(4);

      // Single 0x54 with latency from start-bit fall to rx_valid.
      rx_ready = 1'b1;
      vc0 = valid_cycles;
      ferr0 = ferr_total;
      start_cyc = cyc;
      send_frame(8'h54, 1'b1);
      idle_bits(1);
      check_range("single_latency", valid_rise_cyc - start_cyc, NOM_LAT - 1, NOM_LAT + 1);
      check("single_valid_one_cycle", valid_cycles - vc0, 1);
      check("single_no_ferr", ferr_total - ferr0, 0);
      exp_q.push_back(8'h54);
      check_bytes("single");

      // Table-driven frames.
      foreach (vecs[i]) begin
         cnt0 = got_cnt;
         ferr0 = ferr_total;
         send_frame(vecs[i].data, vecs[i].stop_b);
         idle_bits(2);
         check($sformatf("vec%0d_push", i), got_cnt - cnt0, 32'(vecs[i].exp_push));
         check($sformatf("vec%0d_ferr", i), ferr_total - ferr0, 32'(vecs[i].exp_ferr));
         check($sformatf("vec%0d_idle", i), busy, 0);
         if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
         check_bytes($sformatf("vec%0d", i));
      end

      // Ten back-to-back frames with no idle gap.
      cnt0 = got_cnt;
      ferr0 = ferr_total;
      ovr0 = ovr_total;
      for (int i = 0; i < 10; i++) begin
         send_frame(8'h54, 1'b1);
         exp_q.push_back(8'h54);
      end
      check("b2b_busy_after_last_stop", busy, 0);
      idle_bits(1);
      check("b2b_count", got_cnt - cnt0, 10);
      check("b2b_ferr", ferr_total - ferr0, 0);
      check("b2b_ovr", ovr_total - ovr0, 0);
      check_bytes("b2b");

      // Fill the FIFO without reading, then overflow it.
      rx_ready = 1'b0;
      cnt0 = got_cnt;
      ovr0 = ovr_total;
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
      idle_bits(1);
      check("ovr_none_after_4", ovr_total - ovr0, 0);
      check("full_valid", rx_valid, 1);
      check("full_head", rx_data, 8'h01);
      send_frame(8'h05, 1'b1);
      idle_bits(1);
      check("ovr_on_5th", ovr_total - ovr0, 1);
      check("ovr_head_kept", rx_data, 8'h01);
      // Pop exactly on the push edge while full: both must be accepted.
      fork
         send_frame(8'h06, 1'b1);
         begin
            repeat (NOM_LAT - 1) @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
         end
      join
      idle_bits(1);
      check("full_pushpop_no_ovr", ovr_total - ovr0, 1);
      check("full_pushpop_popped", got_cnt - cnt0, 1);
      check("full_pushpop_head", rx_data, 8'h02);
      rx_ready = 1'b1;
      wait_cycles(8);
      check("drain_empty", rx_valid, 0);
      check("drain_data_zero", rx_data, 8'h00);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h04);
      exp_q.push_back(8'h06);
      check_bytes("drain");

      // Short low glitch, well under half a bit.
      cnt0 = got_cnt;
      ferr0 = ferr_total;
      br0 = busy_rise_cyc;
      rx = 1'b0;
      wait_cycles(10);
      rx = 1'b1;
      wait_cycles(2 * CPB);
      check("glitch_busy_rose", (busy_rise_cyc != br0), 1);
      check_range("glitch_busy_len", busy_fall_cyc - busy_rise_cyc, 1, HALF + 3);
      check("glitch_no_push", got_cnt - cnt0, 0);
      check("glitch_no_ferr", ferr_total - ferr0, 0);
      check("glitch_idle", busy, 0);

      // Bad stop bit, line held low three more bit times, then a good 0xA5.
      cnt0 = got_cnt;
      ferr0 = ferr_total;
      send_frame(8'h33, 1'b0);
      rx = 1'b0;
      wait_cycles(3 * CPB);
      idle_bits(1);
      check("ferr_once", ferr_total - ferr0, 1);
      check("ferr_no_push", got_cnt - cnt0, 0);
      check("ferr_recovered", busy, 0);
      send_frame(8'hA5, 1'b1);
      idle_bits(1);
      check("ferr_then_good_ferr", ferr_total - ferr0, 1);
      exp_q.push_back(8'hA5);
      check_bytes("after_ferr");

      // Buffered byte, then reset in the middle of data bit 3 of 0x54.
      rx_ready = 1'b0;
      cnt0 = got_cnt;
      send_frame(8'h7E, 1'b1);
      idle_bits(1);
      check("pre_reset_valid", rx_valid, 1);
      pd = 8'h54;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(pd[i]);
      rx = pd[3];
      wait_cycles(HALF);
      rst_n = 1'b0;
      wait_cycles(2);
      check("midframe_reset_outputs", {rx_data, rx_valid, frame_err, overrun, busy}, 32'h0);
      rx = 1'b1;
      wait_cycles(2);
      rst_n = 1'b1;
      rx_ready = 1'b1;
      idle_bits(12);
      check("midframe_no_byte", got_cnt - cnt0, 0);
      check("midframe_idle", busy, 0);
      send_frame(8'hC3, 1'b1);
      idle_bits(1);
      exp_q.push_back(8'hC3);
      check_bytes("after_reset");

      // Line still low at reset release: one frame error, then wait in RECOVER.
      rx = 1'b0;
      rst_n = 1'b0;
      wait_cycles(3);
      cnt0 = got_cnt;
      ferr0 = ferr_total;
      rst_n = 1'b1;
      wait_cycles(12 * CPB);
      check("lowrel_one_ferr", ferr_total - ferr0, 1);
      check("lowrel_busy_held", busy, 1);
      rx = 1'b1;
      wait_cycles(8);
      check("lowrel_released", busy, 0);
      check("lowrel_no_push", got_cnt - cnt0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Synthesizable 8N1 UART receiver with a small output FIFO. It sits between the board's serial RX pin and the encryptor datapath, and turns the asynchronous serial stream into bytes presented on a valid/ready interface. Mid-bit sampling rejects start-bit glitches. Framing errors and FIFO overruns are reported as one-cycle pulses.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate; `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division, 868 at defaults).
- `FIFO_DEPTH`, default 4: output buffer entries; must be a power of two, ≥2.
- `clk`  in  1  system clock; all logic rises on the posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  raw serial input, idle high, asynchronous to `clk`.
- `rx_ready`  in  1  consumer accepts the head byte this cycle.
- `rx_data`  out  8  FIFO head byte (show-ahead); reset 8'h00.
- `rx_valid`  out  1  FIFO non-empty; reset 0.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low; reset 0.
- `overrun`  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full; reset 0.
- `busy`  out  1  FSM not in IDLE; reset 0.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`. All FSM decisions use `rx_s`.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- Bit counter `cnt` counts 0..limit-1. The bit is sampled on the cycle where `cnt == limit-1`, and the state advances on the next edge with `cnt` cleared.
- FSM states and transitions:
  - IDLE: go to START when `rx_s == 0`.
  - START: limit = `CLKS_PER_BIT/2`. If the sample is 1, treat it as a glitch and go to IDLE. If 0, go to DATA.
  - DATA: limit = `CLKS_PER_BIT`. On each sample, `shreg <= {rx_s, shreg[7:1]}`. After the 8th sample go to STOP.
  - STOP: limit = `CLKS_PER_BIT`. A sample of 1 pushes `shreg` and goes to IDLE. A sample of 0 pulses `frame_err`, pushes nothing, and goes to RECOVER.
  - RECOVER: wait for `rx_s == 1` (break or stuck-low line), then go to IDLE. A held-low line produces exactly one `frame_err`.
- FIFO semantics:
  - Pop when `rx_valid && rx_ready`.
  - Push when a good stop bit is sampled.
  - Push and pop in the same cycle is always accepted, including when the FIFO is full; occupancy stays unchanged.
  - Push when full with no pop drops the new byte, pulses `overrun`, and leaves the contents untouched.
- `rx_ready` while empty is ignored.
- Reset mid-frame: the FSM returns to IDLE, the FIFO is emptied, and every output takes its reset value. The remainder of the interrupted frame is received only if a later falling edge arrives. A line still low at reset release starts a frame (which then errors and enters RECOVER).

## Timing
- Let t0 be the first `clk` edge at which raw `rx` is sampled 0. Then:
  - `rx_s` falls at t0+2.
  - The stop bit is sampled at t0+2+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`.
  - `rx_valid` rises one edge after that (8249 cycles at defaults). The bench allows ±1 cycle for synchronizer phase.
- `frame_err` and `overrun` assert in the cycle after the stop-bit sample, for exactly one cycle.
- The FSM is back in IDLE one cycle after the stop sample, so it tolerates back-to-back frames with zero idle time and ±3% baud mismatch.
- `rx_data` and `rx_valid` change only on `clk` edges. A pop is seen at the next edge, when the head advances.

## Structure
- Package `uart_pkg`: the FSM state enum (IDLE, START, DATA, STOP, RECOVER) and the function computing `CLKS_PER_BIT`.
- Sub-module `uart_rx_fifo` provides a synchronous show-ahead FIFO with pointers one bit wider than the address, plus the `overrun` logic. The core instantiates it once.
- The counter width is `$clog2(CLKS_PER_BIT)`.

## Test plan
- Single 0x54 at 115200, 100 MHz clk (8680 ns bit time), `rx_ready` = 1. Expected: `rx_valid` pulses one cycle with `rx_data` = 0x54, `frame_err` = 0.
- Ten back-to-back 0x54 frames with no idle gap, `rx_ready` = 1. Expected: exactly 10 accepted bytes, all 0x54, no errors, and `busy` = 0 after the last stop bit.
- Bytes 0x01, 0x02, 0x03, 0x04, 0x05 with `rx_ready` = 0. Expected: `overrun` pulses once, on the 5th byte. Raising `rx_ready` then drains 0x01–0x04 in order, and `rx_valid` = 0 afterwards.
- A 200-cycle low glitch on `rx`. Expected: `busy` rises, then returns to 0 within `CLKS_PER_BIT/2`+3 cycles; no push, no `frame_err`.
- A frame with a 0 stop bit, the line held low for 3 bit times, then a valid 0xA5. Expected: one `frame_err`, no push for the bad frame, then 0xA5 received.
- `rst_n` pulsed low in the middle of the 4th data bit of 0x54. Expected: all outputs at reset values, no byte delivered; the next 0xC3 frame is received correctly.
